// File: rtl/bsg_relay_arb_pkg.sv
// Shared types and helpers for the relay FIFO round-robin arbiter.
//   state_e : arbitration FSM state (idle round-robin vs. burst lock)
//   rr_scan : rotating-priority search over a request vector
package bsg_relay_arb_pkg;

  typedef enum logic [0:0] {
    e_idle  = 1'b0,
    e_burst = 1'b1
  } state_e;

  // Widest request vector the scan helper supports.
  localparam int max_chan_lp = 64;

  // Returns the first index i with req[i]=1, scanning from ptr upward and
  // wrapping at n. Returns -1 when no request is set. ptr must be < n.
  function automatic int rr_scan(input logic [max_chan_lp-1:0] req,
                                 input int ptr,
                                 input int n);
    int res;
    int idx;
    res = -32'sd1;
    idx = 32'sd0;
    for (int k = 0; k < max_chan_lp; k++) begin
      if ((k < n) && (res < 32'sd0)) begin
        idx = ptr + k;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (req[idx[5:0]]) begin
          res = idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bsg_relay_arb_two_buf.sv
// Two-entry ping-pong buffer used as the relay stage behind the arbiter.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset (control flags only)
//   enq_i, data_i  : write request and word; ignored while full
//   deq_i          : read request; ignored while empty
//   full_o/empty_o : registered occupancy flags
//   data_o         : word at the head of the buffer
module bsg_relay_arb_two_buf #(
  parameter int width_p = 18
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_mem [0:1];
  logic               r_head;
  logic               r_tail;
  logic               r_full;
  logic               r_empty;
  logic               w_enq;
  logic               w_deq;

  assign w_enq = enq_i & ~r_full;
  assign w_deq = deq_i & ~r_empty;

  // Payload storage: no reset, contents only meaningful while flagged valid.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_tail] <= data_i;
    end
  end

  // Pointer and occupancy flags; simultaneous enq+deq keeps occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_enq) begin
        r_tail <= ~r_tail;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      case ({w_enq, w_deq})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= ~r_empty;
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= ~r_full;
        end
        default: begin
          r_full  <= r_full;
          r_empty <= r_empty;
        end
      endcase
    end
  end

  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign data_o  = r_mem[r_head];

endmodule

// File: rtl/bsg_relay_fifo_rr_arb.sv
// Round-robin arbiter with optional burst lock feeding a two-entry relay buffer.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   v_i, data_i    : per-channel valid and payload (channel i at [i*width_p +: width_p])
//   ready_o        : per-channel ready, one-hot or zero
//   v_o, data_o    : head beat valid and payload
//   id_o           : source channel of the head beat
//   ready_i        : downstream ready; a beat leaves when v_o & ready_i
module bsg_relay_fifo_rr_arb
  import bsg_relay_arb_pkg::*;
#(
  parameter  int num_in_p    = 4,
  parameter  int width_p     = 16,
  parameter  int max_burst_p = 4,
  localparam int id_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         ready_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic [id_width_lp-1:0]      id_o,
  input  logic                        ready_i
);

  localparam int cnt_width_lp = $clog2(max_burst_p + 1);

  state_e                         r_state;
  logic [id_width_lp-1:0]         r_rr_ptr;
  logic [id_width_lp-1:0]         r_owner;
  logic [cnt_width_lp-1:0]        r_beat_cnt;

  logic [max_chan_lp-1:0]         w_req_ext;
  int                             w_scan_idx;
  logic                           w_owner_hold;
  logic                           w_grant_v;
  logic [id_width_lp-1:0]         w_grant;
  logic [id_width_lp-1:0]         w_rr_next;
  logic [num_in_p-1:0]            w_ready;
  logic                           w_accept;
  logic [width_p-1:0]             w_grant_data;
  logic [id_width_lp+width_p-1:0] w_enq_data;
  logic [id_width_lp+width_p-1:0] w_head;
  logic                           w_buf_full;
  logic                           w_buf_empty;
  logic                           w_deq;

  // The lock only holds while the owner keeps requesting; otherwise fall back
  // to the rotating scan in the same cycle so no bubble is inserted.
  assign w_owner_hold = (r_state == e_burst) & v_i[r_owner];

  // Grant selection: burst owner first, else rotating scan from rr_ptr.
  always_comb begin
    w_req_ext = {max_chan_lp{1'b0}};
    w_req_ext[num_in_p-1:0] = v_i;
    w_scan_idx = rr_scan(w_req_ext, int'(r_rr_ptr), num_in_p);
    if (w_owner_hold) begin
      w_grant   = r_owner;
      w_grant_v = 1'b1;
    end else begin
      w_grant   = w_scan_idx[id_width_lp-1:0];
      w_grant_v = (w_scan_idx >= 32'sd0);
    end
  end

  // Ready is gated by the registered full flag only, never by ready_i, and
  // forced low while reset is asserted.
  always_comb begin
    w_ready = {num_in_p{1'b0}};
    if (w_grant_v & ~w_buf_full & ~reset_i) begin
      w_ready[w_grant] = 1'b1;
    end else begin
      w_ready = {num_in_p{1'b0}};
    end
  end

  assign ready_o  = w_ready;
  assign w_accept = |w_ready;

  // Next round-robin start point, wrapped explicitly for non-power-of-2 counts.
  always_comb begin
    if (w_grant == id_width_lp'(num_in_p - 1)) begin
      w_rr_next = {id_width_lp{1'b0}};
    end else begin
      w_rr_next = w_grant + id_width_lp'(1'b1);
    end
  end

  assign w_grant_data = data_i[int'(w_grant)*width_p +: width_p];
  assign w_enq_data   = {w_grant, w_grant_data};

  // Burst FSM and round-robin pointer; everything holds when nothing is accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_rr_ptr   <= {id_width_lp{1'b0}};
      r_owner    <= {id_width_lp{1'b0}};
      r_beat_cnt <= {cnt_width_lp{1'b0}};
    end else if (w_accept) begin
      r_rr_ptr <= w_rr_next;
      if (w_owner_hold) begin
        // Forced rotation once the owner has sent max_burst_p beats.
        if (r_beat_cnt == cnt_width_lp'(max_burst_p - 1)) begin
          r_state    <= e_idle;
          r_beat_cnt <= {cnt_width_lp{1'b0}};
        end else begin
          r_beat_cnt <= r_beat_cnt + cnt_width_lp'(1'b1);
        end
      end else if (max_burst_p > 1) begin
        r_state    <= e_burst;
        r_owner    <= w_grant;
        r_beat_cnt <= cnt_width_lp'(1'b1);
      end else begin
        r_state    <= e_idle;
        r_beat_cnt <= {cnt_width_lp{1'b0}};
      end
    end
  end

  assign w_deq = ready_i & ~w_buf_empty;

  bsg_relay_arb_two_buf #(
    .width_p(id_width_lp + width_p)
  ) u_buf (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .enq_i  (w_accept),
    .data_i (w_enq_data),
    .deq_i  (w_deq),
    .full_o (w_buf_full),
    .empty_o(w_buf_empty),
    .data_o (w_head)
  );

  assign v_o    = ~w_buf_empty;
  assign data_o = w_head[width_p-1:0];
  assign id_o   = w_head[width_p +: id_width_lp];

endmodule

// File: tb/tb_bsg_relay_fifo_rr_arb.sv
module tb_bsg_relay_fifo_rr_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic clk;
  logic rst;

  // Instance A: max_burst_p = 4
  logic [N-1:0]   a_v_i, a_ready_o;
  logic [N*W-1:0] a_data_i;
  logic           a_v_o, a_ready_i;
  logic [W-1:0]   a_data_o;
  logic [1:0]     a_id_o;

  // Instance B: max_burst_p = 1 (pure round-robin)
  logic [N-1:0]   b_v_i, b_ready_o;
  logic [N*W-1:0] b_data_i;
  logic           b_v_o, b_ready_i;
  logic [W-1:0]   b_data_o;
  logic [1:0]     b_id_o;

  bsg_relay_fifo_rr_arb #(.num_in_p(N), .width_p(W), .max_burst_p(MB)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(a_v_i), .data_i(a_data_i), .ready_o(a_ready_o),
    .v_o(a_v_o), .data_o(a_data_o), .id_o(a_id_o), .ready_i(a_ready_i));

  bsg_relay_fifo_rr_arb #(.num_in_p(N), .width_p(W), .max_burst_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(b_v_i), .data_i(b_data_i), .ready_o(b_ready_o),
    .v_o(b_v_o), .data_o(b_data_o), .id_o(b_id_o), .ready_i(b_ready_i));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan_data(input int c);
    return 16'(32'h1111 * (c + 1));
  endfunction

  function automatic logic [N*W-1:0] all_chan_data();
    logic [N*W-1:0] d;
    for (int c = 0; c < N; c++) d[c*W +: W] = chan_data(c);
    return d;
  endfunction

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_v;
    logic [1:0] exp_id;
  } vec_t;

  vec_t t_rr[8];
  vec_t t_burst[10];

  // ---------------- reference model (instance A) ----------------
  typedef struct {
    int         id;
    logic [W-1:0] d;
  } beat_t;

  beat_t md_q[$];
  int    md_ptr, md_owner, md_sent;
  bit    md_locked;

  function automatic int model_grant(input logic [3:0] v);
    if (md_locked && v[md_owner]) return md_owner;
    for (int k = 0; k < N; k++) begin
      if (v[(md_ptr + k) % N]) return (md_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_q.delete();
    md_ptr = 0; md_owner = 0; md_sent = 0; md_locked = 1'b0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input logic [3:0] v, input logic [N*W-1:0] d, input logic rdy);
    int g;
    bit acc, cont;
    beat_t b;
    g    = model_grant(v);
    acc  = (g >= 0) && (md_q.size() < 2);
    cont = md_locked && v[md_owner];
    if (rdy && md_q.size() > 0) void'(md_q.pop_front());
    if (acc) begin
      b.id = g;
      b.d  = d[g*W +: W];
      md_q.push_back(b);
      md_ptr = (g + 1) % N;
      if (cont) begin
        md_sent = md_sent + 1;
        if (md_sent == MB) begin
          md_locked = 1'b0;
          md_sent   = 0;
        end
      end else if (MB > 1) begin
        md_locked = 1'b1;
        md_owner  = g;
        md_sent   = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_v_i = 4'b0000; b_v_i = 4'b0000;
    a_ready_i = 1'b0; b_ready_i = 1'b0;
    a_data_i = all_chan_data(); b_data_i = all_chan_data();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic a_drive(input logic [3:0] v, input logic rdy);
    @(negedge clk);
    a_v_i = v;
    a_ready_i = rdy;
    #1;
  endtask

  initial begin
    // Pure round-robin, all channels requesting.
    t_rr[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    t_rr[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    t_rr[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    t_rr[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    t_rr[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    t_rr[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    t_rr[6] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    t_rr[7] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    // Burst of 4 alternating between channels 1 and 2.
    t_burst[0] = '{4'b0110, 1'b1, 4'b0010, 1'b0, 2'd0};
    t_burst[1] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
    t_burst[2] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
    t_burst[3] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
    t_burst[4] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd1};
    t_burst[5] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
    t_burst[6] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
    t_burst[7] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
    t_burst[8] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd2};
    t_burst[9] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};

    rst = 1'b1;
    a_v_i = 4'b0000; b_v_i = 4'b0000;
    a_ready_i = 1'b0; b_ready_i = 1'b0;
    a_data_i = all_chan_data(); b_data_i = all_chan_data();

    // Reset state
    @(negedge clk); #1;
    chk("reset_v_o", 32'(a_v_o), 32'd0);
    chk("reset_ready_o", 32'(a_ready_o), 32'd0);
    chk("reset_rr_v_o", 32'(b_v_o), 32'd0);
    a_v_i = 4'b1111;
    #1;
    chk("reset_ready_o_with_v", 32'(a_ready_o), 32'd0);
    @(negedge clk);
    a_v_i = 4'b0000;
    rst = 1'b0;

    // Pure round-robin table (instance B)
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_v_i = t_rr[i].v;
      b_ready_i = t_rr[i].rdy;
      #1;
      chk($sformatf("rr_ready[%0d]", i), 32'(b_ready_o), 32'(t_rr[i].exp_ready));
      chk($sformatf("rr_v[%0d]", i), 32'(b_v_o), 32'(t_rr[i].exp_v));
      if (t_rr[i].exp_v) begin
        chk($sformatf("rr_id[%0d]", i), 32'(b_id_o), 32'(t_rr[i].exp_id));
        chk($sformatf("rr_data[%0d]", i), 32'(b_data_o), 32'(chan_data(int'(t_rr[i].exp_id))));
      end
    end

    // Burst table (instance A)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_drive(t_burst[i].v, t_burst[i].rdy);
      chk($sformatf("burst_ready[%0d]", i), 32'(a_ready_o), 32'(t_burst[i].exp_ready));
      chk($sformatf("burst_v[%0d]", i), 32'(a_v_o), 32'(t_burst[i].exp_v));
      if (t_burst[i].exp_v) begin
        chk($sformatf("burst_id[%0d]", i), 32'(a_id_o), 32'(t_burst[i].exp_id));
      end
    end

    // Backpressure: two beats fill the buffer, then drain in order
    do_reset();
    a_data_i[15:0] = 16'hA5A5;
    a_drive(4'b0001, 1'b0);
    chk("bp_ready_c0", 32'(a_ready_o), 32'h1);
    chk("bp_v_c0", 32'(a_v_o), 32'd0);
    @(negedge clk); a_data_i[15:0] = 16'h5A5A; #1;
    chk("bp_ready_c1", 32'(a_ready_o), 32'h1);
    chk("bp_data_c1", 32'(a_data_o), 32'hA5A5);
    @(negedge clk); a_data_i[15:0] = 16'h1234; #1;
    chk("bp_full_ready", 32'(a_ready_o), 32'h0);
    chk("bp_full_v", 32'(a_v_o), 32'h1);
    a_drive(4'b0001, 1'b1);
    chk("bp_full_deq_ready", 32'(a_ready_o), 32'h0);
    chk("bp_head_a5", 32'(a_data_o), 32'hA5A5);
    chk("bp_id_a5", 32'(a_id_o), 32'd0);
    a_drive(4'b0001, 1'b1);
    chk("bp_head_5a", 32'(a_data_o), 32'h5A5A);
    chk("bp_id_5a", 32'(a_id_o), 32'd0);
    chk("bp_resume_ready", 32'(a_ready_o), 32'h1);
    a_drive(4'b0001, 1'b1);
    chk("bp_head_1234", 32'(a_data_o), 32'h1234);

    // Burst owner drops out: immediate hand-over, new count starts at 1
    do_reset();
    a_drive(4'b1010, 1'b1);
    chk("drop_c0_ready", 32'(a_ready_o), 32'h2);
    a_drive(4'b1010, 1'b1);
    chk("drop_c1_ready", 32'(a_ready_o), 32'h2);
    a_drive(4'b1000, 1'b1);
    chk("drop_handover_ready", 32'(a_ready_o), 32'h8);
    chk("drop_c2_id", 32'(a_id_o), 32'd1);
    for (int i = 3; i < 6; i++) begin
      a_drive(4'b1010, 1'b1);
      chk($sformatf("drop_c%0d_ready", i), 32'(a_ready_o), 32'h8);
    end
    a_drive(4'b1010, 1'b1);
    chk("drop_rotate_ready", 32'(a_ready_o), 32'h2);
    chk("drop_rotate_id", 32'(a_id_o), 32'd3);

    // Reset pulse mid-burst with a full buffer
    do_reset();
    a_drive(4'b0010, 1'b0);
    a_drive(4'b0010, 1'b0);
    a_drive(4'b0010, 1'b0);
    chk("midrst_full_ready", 32'(a_ready_o), 32'h0);
    chk("midrst_full_v", 32'(a_v_o), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_v_clear", 32'(a_v_o), 32'h0);
    a_v_i = 4'b1111;
    a_ready_i = 1'b1;
    #1;
    chk("midrst_ready_in_reset", 32'(a_ready_o), 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst_after_v", 32'(a_v_o), 32'h0);
    chk("midrst_first_grant", 32'(a_ready_o), 32'h1);
    @(negedge clk); #1;
    chk("midrst_first_id", 32'(a_id_o), 32'd0);
    chk("midrst_first_data", 32'(a_data_o), 32'(chan_data(0)));

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic [3:0] exp_rdy;
      @(negedge clk);
      if ($urandom_range(0, 9) < 3) a_v_i = 4'($urandom_range(0, 15));
      a_ready_i = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) a_data_i[c*W +: W] = 16'($urandom);
      #1;
      g = model_grant(a_v_i);
      exp_rdy = ((g >= 0) && (md_q.size() < 2)) ? 4'(1 << g) : 4'b0000;
      chk("rand_ready", 32'(a_ready_o), 32'(exp_rdy));
      chk("rand_v", 32'(a_v_o), (md_q.size() > 0) ? 32'd1 : 32'd0);
      if (md_q.size() > 0) begin
        chk("rand_id", 32'(a_id_o), 32'(md_q[0].id));
        chk("rand_data", 32'(a_data_o), 32'(md_q[0].d));
      end
      model_step(a_v_i, a_data_i, a_ready_i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
